// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: merges the CPU's inst and data SRAM-like ports onto one AXI3
// master. Only one AXI transaction is in flight at a time, and the data port wins
// arbitration ties.
// Optional build macro BRIDGE_PERF_CNT_EN adds perf_rd_cnt / perf_wr_cnt.
module cpu_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic        bvalid,
    output logic        bready
`ifdef BRIDGE_PERF_CNT_EN
    ,
    output logic [31:0] perf_rd_cnt,
    output logic [31:0] perf_wr_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        sel_data_q, sel_data_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        inst_data_ok_q, inst_data_ok_d;
    logic        data_data_ok_q, data_data_ok_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        r_hs, b_hs, aw_hs, w_hs;
    logic        unused_ok;

    // Inst port never writes, and with one outstanding transaction IDs/rlast are redundant.
    assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rlast, bid};

    // AXI channel drive, decoded from the state register and latched request.
    assign arvalid = (state_q == RD_ADDR);
    assign arid    = sel_data_q ? DATA_ID : INST_ID;
    assign araddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign rready  = (state_q == RD_DATA);
    assign awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign awid    = DATA_ID;
    assign awaddr  = addr_q;
    assign awsize  = {1'b0, size_q};
    assign wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign wid     = DATA_ID;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign bready  = (state_q == WR_RESP);

    assign r_hs  = rvalid & rready;
    assign b_hs  = bvalid & bready;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    assign inst_sram_data_ok = inst_data_ok_q;
    assign data_sram_data_ok = data_data_ok_q;
    assign inst_sram_rdata   = inst_rdata_q;
    assign data_sram_rdata   = data_rdata_q;

    // Next-state, request latch, write handshake tracking and completion pulses.
    always_comb begin
        state_d           = state_q;
        sel_data_d        = sel_data_q;
        size_d            = size_q;
        addr_d            = addr_q;
        wstrb_d           = wstrb_q;
        wdata_d           = wdata_q;
        aw_done_d         = aw_done_q;
        w_done_d          = w_done_q;
        inst_data_ok_d    = 1'b0;
        data_data_ok_d    = 1'b0;
        inst_rdata_d      = inst_rdata_q;
        data_rdata_d      = data_rdata_q;
        inst_sram_addr_ok = 1'b0;
        data_sram_addr_ok = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_sram_req) begin
                    data_sram_addr_ok = 1'b1;
                    sel_data_d        = 1'b1;
                    size_d            = data_sram_size;
                    addr_d            = data_sram_addr;
                    wstrb_d           = data_sram_wstrb;
                    wdata_d           = data_sram_wdata;
                    state_d           = data_sram_wr ? WR_REQ : RD_ADDR;
                end else if (inst_sram_req) begin
                    inst_sram_addr_ok = 1'b1;
                    sel_data_d        = 1'b0;
                    size_d            = inst_sram_size;
                    addr_d            = inst_sram_addr;
                    wstrb_d           = 4'h0;
                    wdata_d           = 32'h0;
                    state_d           = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    if (sel_data_q) begin
                        data_rdata_d   = rdata;
                        data_data_ok_d = 1'b1;
                    end else begin
                        inst_rdata_d   = rdata;
                        inst_data_ok_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                // AW and W may complete in either order or together.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end else begin
                    aw_done_d = aw_done_q || aw_hs;
                    w_done_d  = w_done_q || w_hs;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    data_data_ok_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sel_data_q     <= 1'b0;
            size_q         <= 2'd0;
            addr_q         <= 32'h0;
            wstrb_q        <= 4'h0;
            wdata_q        <= 32'h0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;
            inst_rdata_q   <= 32'h0;
            data_rdata_q   <= 32'h0;
        end else begin
            state_q        <= state_d;
            sel_data_q     <= sel_data_d;
            size_q         <= size_d;
            addr_q         <= addr_d;
            wstrb_q        <= wstrb_d;
            wdata_q        <= wdata_d;
            aw_done_q      <= aw_done_d;
            w_done_q       <= w_done_d;
            inst_data_ok_q <= inst_data_ok_d;
            data_data_ok_q <= data_data_ok_d;
            inst_rdata_q   <= inst_rdata_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

`ifdef BRIDGE_PERF_CNT_EN
    logic [31:0] perf_rd_cnt_q, perf_rd_cnt_d;
    logic [31:0] perf_wr_cnt_q, perf_wr_cnt_d;

    // Count R and B handshakes; both counters wrap naturally.
    always_comb begin
        perf_rd_cnt_d = perf_rd_cnt_q;
        perf_wr_cnt_d = perf_wr_cnt_q;
        if (r_hs) perf_rd_cnt_d = perf_rd_cnt_q + 32'd1;
        if (b_hs) perf_wr_cnt_d = perf_wr_cnt_q + 32'd1;
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_rd_cnt_q <= 32'h0;
            perf_wr_cnt_q <= 32'h0;
        end else begin
            perf_rd_cnt_q <= perf_rd_cnt_d;
            perf_wr_cnt_q <= perf_wr_cnt_d;
        end
    end

    assign perf_rd_cnt = perf_rd_cnt_q;
    assign perf_wr_cnt = perf_wr_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: cycle-exact vector table for cpu_axi_bridge plus hand-written
// sequences for reset abandonment and a delayed-handshake write.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic        bvalid, bready;
`ifdef BRIDGE_PERF_CNT_EN
    logic [31:0] perf_rd_cnt, perf_wr_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bvalid(bvalid), .bready(bready)
`ifdef BRIDGE_PERF_CNT_EN
        , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt)
`endif
    );

    // ib  = {ireq, iwr, dreq, dwr, arready, rvalid, awready, wready, bvalid}
    // ec  = {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, arvalid, rready, awvalid, wvalid, bready}
    typedef struct {
        string       nm;
        logic [8:0]  ib;
        logic [1:0]  dsz;
        logic [31:0] ia, da;
        logic [3:0]  dws;
        logic [31:0] dwd, rdin;
        logic [8:0]  ec;
        logic [3:0]  eid;
        logic [2:0]  esz;
        logic [31:0] eaddr;
        logic [3:0]  ews;
        logic [31:0] ewd, erd;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [8:0] ib, input logic [1:0] dsz,
                                input logic [31:0] ia, input logic [31:0] da, input logic [3:0] dws,
                                input logic [31:0] dwd, input logic [31:0] rdin, input logic [8:0] ec,
                                input logic [3:0] eid, input logic [2:0] esz, input logic [31:0] eaddr,
                                input logic [3:0] ews, input logic [31:0] ewd, input logic [31:0] erd);
        vec_t v;
        v.nm = nm; v.ib = ib; v.dsz = dsz; v.ia = ia; v.da = da; v.dws = dws; v.dwd = dwd;
        v.rdin = rdin; v.ec = ec; v.eid = eid; v.esz = esz; v.eaddr = eaddr; v.ews = ews;
        v.ewd = ewd; v.erd = erd;
        return v;
    endfunction

    function automatic logic [8:0] ctl();
        return {inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok,
                arvalid, rready, awvalid, wvalid, bready};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_in();
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2; inst_sram_addr = 32'h0;
        inst_sram_wstrb = 4'h0; inst_sram_wdata = 32'h0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0; data_sram_addr = 32'h0;
        data_sram_wstrb = 4'h0; data_sram_wdata = 32'h0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rid = 4'h0; rlast = 1'b1;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 4'h0;
    endtask

    task automatic apply(input vec_t v);
        clear_in();
        {inst_sram_req, inst_sram_wr, data_sram_req, data_sram_wr, arready, rvalid, awready, wready, bvalid} = v.ib;
        inst_sram_addr  = v.ia;
        data_sram_size  = v.dsz;
        data_sram_addr  = v.da;
        data_sram_wstrb = v.dws;
        data_sram_wdata = v.dwd;
        rdata           = v.rdin;
    endtask

    task automatic check_vec(input vec_t v);
        chk({v.nm, "_ctl"}, 64'(ctl()), 64'(v.ec));
        if (v.ec[4]) chk({v.nm, "_ar"}, 64'({arid, arsize, araddr}), 64'({v.eid, v.esz, v.eaddr}));
        if (v.ec[2]) chk({v.nm, "_aw"}, 64'({awid, awsize, awaddr}), 64'({v.eid, v.esz, v.eaddr}));
        if (v.ec[1]) chk({v.nm, "_w"}, 64'({wid, wstrb, wdata, wlast}), 64'({v.eid, v.ews, v.ewd, 1'b1}));
        if (v.ec[6]) chk({v.nm, "_irdata"}, 64'(inst_sram_rdata), 64'(v.erd));
        if (v.ec[5]) chk({v.nm, "_drdata"}, 64'(data_sram_rdata), 64'(v.erd));
    endtask

    vec_t vecs[$];
    int   aw_cnt, w_cnt;
    logic got;

    initial begin
        // Cycle-by-cycle vectors: inputs applied at negedge, outputs checked before the next posedge.
        vecs.push_back(mk("i0_aok",   9'b100000000, 2'd0, 32'h1C000000, 32'h0,     4'h0, 32'h0,        32'h0,        9'b100000000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("i0_ar",    9'b000010000, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000010000, 4'd0, 3'd2, 32'h1C000000, 4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("i0_r",     9'b000001000, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h02800404, 9'b000001000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("i0_dok",   9'b000000000, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b001000000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h02800404));
        vecs.push_back(mk("arb_aok",  9'b111000000, 2'd2, 32'h1C000004, 32'h1000,  4'h0, 32'h0,        32'h0,        9'b010000000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("arb_ar0",  9'b110000000, 2'd0, 32'h1C000004, 32'h0,     4'h0, 32'h0,        32'h0,        9'b000010000, 4'd1, 3'd2, 32'h1000,     4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("arb_ar1",  9'b110010000, 2'd0, 32'h1C000004, 32'h0,     4'h0, 32'h0,        32'h0,        9'b000010000, 4'd1, 3'd2, 32'h1000,     4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("arb_r0",   9'b110000000, 2'd0, 32'h1C000004, 32'h0,     4'h0, 32'h0,        32'h0,        9'b000001000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("arb_r1",   9'b110001000, 2'd0, 32'h1C000004, 32'h0,     4'h0, 32'h0,        32'hCAFEF00D, 9'b000001000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("arb_iaok", 9'b110000000, 2'd0, 32'h1C000004, 32'h0,     4'h0, 32'h0,        32'h0,        9'b100100000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'hCAFEF00D));
        vecs.push_back(mk("arb_iar",  9'b000010000, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000010000, 4'd0, 3'd2, 32'h1C000004, 4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("arb_ir",   9'b000001000, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h12345678, 9'b000001000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("arb_idok", 9'b000000000, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b001000000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h12345678));
        vecs.push_back(mk("bw_aok",   9'b001100000, 2'd0, 32'h0,        32'h1003,  4'h8, 32'hAB000000, 32'h0,        9'b010000000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("bw_w",     9'b000000010, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000000110, 4'd1, 3'd0, 32'h1003,     4'h8, 32'hAB000000, 32'h0));
        vecs.push_back(mk("bw_gap",   9'b000000000, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000000100, 4'd1, 3'd0, 32'h1003,     4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("bw_aw",    9'b000000100, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000000100, 4'd1, 3'd0, 32'h1003,     4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("bw_b0",    9'b000000000, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000000001, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("bw_b1",    9'b000000001, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000000001, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("bw_dok",   9'b000000000, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000100000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'hCAFEF00D));
        vecs.push_back(mk("sw_aok",   9'b001100000, 2'd2, 32'h0,        32'h2000,  4'hF, 32'hDEADBEEF, 32'h0,        9'b010000000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("sw_aww",   9'b000000110, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000000110, 4'd1, 3'd2, 32'h2000,     4'hF, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk("sw_b",     9'b000000001, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000000001, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("aw_dokaok",9'b001100000, 2'd1, 32'h0,        32'h3002,  4'hC, 32'hBEEF0000, 32'h0,        9'b010100000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'hCAFEF00D));
        vecs.push_back(mk("aw_aw",    9'b000000100, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000000110, 4'd1, 3'd1, 32'h3002,     4'hC, 32'hBEEF0000, 32'h0));
        vecs.push_back(mk("aw_wait",  9'b000000100, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000000010, 4'd1, 3'd0, 32'h0,        4'hC, 32'hBEEF0000, 32'h0));
        vecs.push_back(mk("aw_w",     9'b000000010, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000000010, 4'd1, 3'd0, 32'h0,        4'hC, 32'hBEEF0000, 32'h0));
        vecs.push_back(mk("aw_b",     9'b000000001, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000000001, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h0));
        vecs.push_back(mk("aw_dok",   9'b000000000, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000100000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'hCAFEF00D));
        vecs.push_back(mk("aw_quiet", 9'b000000000, 2'd0, 32'h0,        32'h0,     4'h0, 32'h0,        32'h0,        9'b000000000, 4'd0, 3'd0, 32'h0,        4'h0, 32'h0,        32'h0));

        // Reset state
        clear_in();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("rst_ctl", 64'(ctl()), 64'h0);
        chk("rst_rdata", 64'({inst_sram_rdata, data_sram_rdata}), 64'h0);
`ifdef BRIDGE_PERF_CNT_EN
        chk("rst_perf", 64'({perf_rd_cnt, perf_wr_cnt}), 64'h0);
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i]);
            #2;
            check_vec(vecs[i]);
        end
`ifdef BRIDGE_PERF_CNT_EN
        chk("perf_rd_3", 64'(perf_rd_cnt), 64'd3);
        chk("perf_wr_3", 64'(perf_wr_cnt), 64'd3);
`endif

        // Reset during RD_DATA abandons the read; a late R beat in IDLE is ignored.
        @(negedge clk); clear_in(); data_sram_req = 1'b1; data_sram_addr = 32'h4000; data_sram_size = 2'd2;
        #2 chk("rr_aok", 64'(ctl()), 64'(9'b010000000));
        @(negedge clk); clear_in(); arready = 1'b1;
        #2 chk("rr_ar", 64'(ctl()), 64'(9'b000010000));
        @(negedge clk); clear_in(); reset = 1'b1;
        #2 chk("rr_rdata_state", 64'(ctl()), 64'(9'b000001000));
        @(negedge clk); clear_in(); reset = 1'b0; rvalid = 1'b1; rdata = 32'h55AA55AA;
        #2 chk("rr_idle", 64'(ctl()), 64'h0);
        chk("rr_rdata0", 64'({inst_sram_rdata, data_sram_rdata}), 64'h0);
        @(negedge clk); clear_in(); inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000010;
        #2 chk("rr_noDok_iaok", 64'(ctl()), 64'(9'b100000000));
        @(negedge clk); clear_in(); arready = 1'b1;
        #2 chk("rr_iar", 64'({ctl(), arid, arsize, araddr}), 64'({9'b000010000, 4'd0, 3'd2, 32'h1C000010}));
        @(negedge clk); clear_in(); rvalid = 1'b1; rdata = 32'h0BADC0DE;
        #2 chk("rr_ir", 64'(ctl()), 64'(9'b000001000));
        @(negedge clk); clear_in();
        #2 chk("rr_idok", 64'({ctl(), inst_sram_rdata, data_sram_rdata}), 64'({9'b001000000, 32'h0BADC0DE, 32'h0}));
`ifdef BRIDGE_PERF_CNT_EN
        chk("perf_after_rst", 64'({perf_rd_cnt, perf_wr_cnt}), 64'({32'd1, 32'd0}));
`endif

        // Write with AW at +2, W at +4, B at +7; bounded wait for data_ok.
        @(negedge clk); clear_in(); data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd2;
        data_sram_addr = 32'h5000; data_sram_wstrb = 4'hF; data_sram_wdata = 32'h11223344;
        #2 chk("dw_aok", 64'(ctl()), 64'(9'b010000000));
        aw_cnt = 0; w_cnt = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk); clear_in();
            awready = (c >= 2); wready = (c >= 4); bvalid = (c >= 7);
            #2;
            if (awvalid && awready) aw_cnt++;
            if (wvalid && wready) w_cnt++;
            if (data_sram_data_ok) got = 1'b1;
        end
        chk("dw_dok_seen", 64'(got), 64'd1);
        chk("dw_aw_beats", 64'(aw_cnt), 64'd1);
        chk("dw_w_beats", 64'(w_cnt), 64'd1);
        @(negedge clk); clear_in();
        #2 chk("dw_single_pulse", 64'(ctl()), 64'h0);
`ifdef BRIDGE_PERF_CNT_EN
        chk("perf_wr_1", 64'(perf_wr_cnt), 64'd1);

        // Wrap: preload the read counter to all-ones, then one read.
        @(negedge clk); clear_in();
        force dut.perf_rd_cnt_q = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.perf_rd_cnt_q;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000020;
        #2 chk("wrap_preload", 64'(perf_rd_cnt), 64'hFFFFFFFF);
        @(negedge clk); clear_in(); arready = 1'b1;
        @(negedge clk); clear_in(); rvalid = 1'b1;
        @(negedge clk); clear_in();
        #2 chk("wrap_zero", 64'(perf_rd_cnt), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
